online_digit_collector: RTL and testbench

//  Sink end of the MSD-first online digit-serial path: the consumer side of the digit-shift/align stage.

---
 rtl/online_digit_collector.sv | 127 ++++++++++++
 tb/tb_online_digit_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/online_digit_collector.sv
// Sink of an MSD-first online digit-serial stream: drops the online-delay digits, packs STAGE
// redundant signed digits into a word, converts it on the fly to two's complement, then holds it.
module online_digit_collector #(
  parameter int STAGE = 4,
  parameter int DELAY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 din_valid,
  input  logic [1:0]           din,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*STAGE-1:0]   y_rd,
  output logic signed [STAGE:0] y_tc,
  output logic                 err_overrun
);

  localparam int WL      = 2 * STAGE;
  localparam int CNT_MAX = (STAGE > DELAY) ? STAGE : DELAY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] COLL_LAST = CNT_W'(STAGE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_COLLECT,
    S_HOLD
  } state_t;

  localparam state_t FIRST_STATE = (DELAY > 0) ? S_SKIP : S_COLLECT;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WL-1:0]          rd_q, rd_d;
  logic signed [STAGE:0]  tc_q, tc_d;
  logic                   err_q, err_d;
  logic signed [STAGE:0]  dval;
  logic                   frame_go;

  // Code 11 contributes zero, same as 00.
  always_comb begin
    dval = '0;
    if (din == 2'b10)      dval = (STAGE+1)'(1);
    else if (din == 2'b01) dval = '1;
  end

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    tc_d     = tc_q;
    err_d    = 1'b0;
    frame_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = din_valid;
        if (start) frame_go = 1'b1;
      end
      S_SKIP: begin
        if (din_valid) begin
          if (cnt_q == SKIP_LAST) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COLLECT: begin
        if (din_valid) begin
          rd_d = {rd_q[WL-3:0], din};
          // Incremental conversion: one shift-and-add per accepted digit.
          tc_d = {tc_q[STAGE-1:0], 1'b0} + dval;
          if (cnt_q == COLL_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        err_d = din_valid;
        if (out_ready) begin
          state_d = S_IDLE;
          if (start) frame_go = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_go) begin
      state_d = FIRST_STATE;
      cnt_d   = '0;
      rd_d    = '0;
      tc_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      tc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign y_rd        = rd_q;
  assign y_tc        = tc_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_online_digit_collector.sv
// Directed bench for online_digit_collector (STAGE=4, DELAY=1) with an expected-result queue.
module tb_online_digit_collector;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              din_valid;
  logic [1:0]        din;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        y_rd;
  logic signed [4:0] y_tc;
  logic              err_overrun;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] rd;
    logic [4:0] tc;
  } exp_t;

  exp_t sb[$];

  online_digit_collector #(.STAGE(4), .DELAY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din(din),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .y_rd(y_rd), .y_tc(y_tc), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of digits d0..d3 (MSD first) as sum d_k * 2^(3-k).
  function automatic exp_t model(input logic [7:0] w);
    exp_t       r;
    int         s;
    logic [1:0] d;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      d = w[7-2*k -: 2];
      if (d == 2'b10)      s += (1 << (3 - k));
      else if (d == 2'b01) s -= (1 << (3 - k));
    end
    r.rd = w;
    r.tc = s[4:0];
    return r;
  endfunction

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put_digit(input logic [1:0] d, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        din_valid = 1'b0;
        tick();
      end
    end
    din_valid = 1'b1;
    din       = d;
    tick();
    din_valid = 1'b0;
    din       = 2'b00;
  endtask

  // One discarded delay digit, then the four digits of w, MSD first.
  task automatic send_digits(input logic [7:0] w, input bit gaps);
    sb.push_back(model(w));
    put_digit(2'b01, gaps);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) put_digit(w[7-2*k -: 2], gaps);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_y_rd"}, {24'd0, y_rd}, {24'd0, e.rd});
      check({tag, "_y_tc"}, {27'd0, y_tc}, {27'd0, e.tc});
    end
  endtask

  task automatic collect_result(input string tag, input bit strict);
    if (strict) begin
      check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
    end else begin
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      check({tag, "_out_valid_timeout"}, {31'd0, out_valid}, 32'd1);
    end
    compare_head(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = 2'b00; out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y_rd", {24'd0, y_rd}, 32'd0);
    check("rst_y_tc", {27'd0, y_tc}, 32'd0);
    check("rst_err", {31'd0, err_overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // Gap-free spec vectors: +7, -15, then code 11 treated as zero.
    start_frame(); send_digits(8'h86, 1'b0); collect_result("plus7", 1'b1);
    start_frame(); send_digits(8'h55, 1'b0); collect_result("minus15", 1'b1);
    start_frame(); send_digits(8'hFE, 1'b0); collect_result("code11", 1'b1);

    // din_valid in IDLE drops the digit and pulses err_overrun once.
    din_valid = 1'b1; din = 2'b10;
    tick();
    din_valid = 1'b0;
    check("idle_err_pulse", {31'd0, err_overrun}, 32'd1);
    check("idle_y_rd_kept", {24'd0, y_rd}, 32'hFE);
    tick();
    check("idle_err_clear", {31'd0, err_overrun}, 32'd0);

    // Random stalls between digits.
    start_frame(); send_digits(8'h86, 1'b1); collect_result("gap_plus7", 1'b0);
    start_frame(); send_digits(8'h55, 1'b1); collect_result("gap_minus15", 1'b0);
    start_frame(); send_digits(8'h92, 1'b1); collect_result("gap_mixed", 1'b0);

    // Back-pressure in HOLD with overrun digits.
    start_frame(); send_digits(8'h86, 1'b0);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; din = 2'b01;
      tick();
      din_valid = 1'b0;
      check("hold_err_pulse", {31'd0, err_overrun}, 32'd1);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_y_rd", {24'd0, y_rd}, 32'h86);
      check("hold_y_tc", {27'd0, y_tc}, 32'h07);
      tick();
      check("hold_err_clear", {31'd0, err_overrun}, 32'd0);
    end
    collect_result("hold_release", 1'b1);

    // Handshake and start together: new frame begins with no bubble.
    start_frame(); send_digits(8'hFE, 1'b0);
    check("chain_latency", {31'd0, out_valid}, 32'd1);
    compare_head("chain_first");
    out_ready = 1'b1; start = 1'b1; din_valid = 1'b1; din = 2'b10;
    tick();
    out_ready = 1'b0; start = 1'b0; din_valid = 1'b0;
    check("chain_busy", {31'd0, busy}, 32'd1);
    check("chain_valid_drop", {31'd0, out_valid}, 32'd0);
    check("chain_err", {31'd0, err_overrun}, 32'd1);
    check("chain_cleared", {24'd0, y_rd}, 32'd0);
    send_digits(8'h55, 1'b0);
    collect_result("chain_second", 1'b1);

    // Asynchronous reset mid-COLLECT aborts the frame.
    start_frame();
    put_digit(2'b10, 1'b0);
    put_digit(2'b10, 1'b0);
    put_digit(2'b01, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_y_rd", {24'd0, y_rd}, 32'd0);
    check("abort_y_tc", {27'd0, y_tc}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_stays_idle", {31'd0, out_valid}, 32'd0);
    start_frame(); send_digits(8'h86, 1'b0); collect_result("after_abort", 1'b1);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
